// File: rtl/serial_word_collector.sv
// Serial-to-parallel capture stage: skips the upstream pipeline-fill cycles, packs
// enabled samples LSB-first into WIDTH-bit words and offers them with a popcount.
module serial_word_collector #(
    parameter int WIDTH       = 8,
    parameter int FILL_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in,
    input  logic                       en,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH+1);
    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH-1);

    typedef enum logic {
        FILL,
        COLLECT
    } state_t;

    localparam state_t RESET_STATE = (FILL_CYCLES == 0) ? COLLECT : FILL;

    state_t           state;
    logic [FW-1:0]    fill_cnt;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] merged;
    logic [CW-1:0]    merged_ones;
    logic             word_done;

    // The completing bit is folded in here so the finished word and its count
    // can be registered on the same edge that captures that bit.
    always_comb begin
        merged = shift;
        merged[bit_idx] = in;
        merged_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            merged_ones = merged_ones + CW'(merged[i]);
        end
        word_done = (state == COLLECT) && en && (bit_idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            fill_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            out_data  <= '0;
            ones_cnt  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (int'(fill_cnt) == FILL_CYCLES - 1) begin
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (en) begin
                        shift <= merged;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    // Collection never stalls: a word finishing while the port is
                    // blocked is discarded and remembered in the sticky flag.
                    if (word_done) begin
                        if (!out_valid || out_ready) begin
                            out_data  <= merged;
                            ones_cnt  <= merged_ones;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized and directed bench for serial_word_collector, checked against a
// bit-queue reference model; a second instance covers WIDTH=4, FILL_CYCLES=0.
module tb_serial_word_collector;

    localparam int WIDTH = 8;
    localparam int FILL  = 4;
    localparam int CW    = $clog2(WIDTH+1);

    logic             clk;
    logic             rst_n;
    logic             in;
    logic             en;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    ones_cnt;
    logic             out_valid;
    logic             overrun;

    logic       rst_n_b;
    logic       in_b;
    logic       en_b;
    logic       ready_b;
    logic [3:0] data_b;
    logic [2:0] ones_b;
    logic       valid_b;
    logic       overrun_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release and the bits gathered so far.
    int               m_since = 0;
    logic             m_bits[$];
    logic [WIDTH-1:0] m_data = '0;
    int               m_ones = 0;
    logic             m_valid = 1'b0;
    logic             m_overrun = 1'b0;

    serial_word_collector #(.WIDTH(WIDTH), .FILL_CYCLES(FILL)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .en(en),
        .out_data(out_data), .ones_cnt(ones_cnt), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    serial_word_collector #(.WIDTH(4), .FILL_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in(in_b), .en(en_b),
        .out_data(data_b), .ones_cnt(ones_b), .out_valid(valid_b),
        .out_ready(ready_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic r, input logic i, input logic e, input logic rd);
        logic [WIDTH-1:0] word;
        int ones;
        if (!r) begin
            m_since = 0;
            m_bits.delete();
            m_data = '0;
            m_ones = 0;
            m_valid = 1'b0;
            m_overrun = 1'b0;
        end else begin
            if (m_since >= FILL && e) begin
                m_bits.push_back(i);
            end
            m_since++;
            if (m_bits.size() == WIDTH) begin
                word = '0;
                ones = 0;
                for (int k = 0; k < WIDTH; k++) begin
                    word = word | (WIDTH'(m_bits[k]) << k);
                    ones += int'(m_bits[k]);
                end
                m_bits.delete();
                if (!m_valid || rd) begin
                    m_data = word;
                    m_ones = ones;
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, compare mid-cycle.
    task automatic applyStimulus(input logic r, input logic i, input logic e, input logic rd);
        rst_n = r;
        in = i;
        en = e;
        out_ready = rd;
        @(posedge clk);
        modelEdge(r, i, e, rd);
        @(negedge clk);
        checkOutput("out_data", 32'(out_data), 32'(m_data));
        checkOutput("ones_cnt", 32'(ones_cnt), 32'(m_ones));
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    task automatic resetAndFill();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_zero", {out_data, ones_cnt, out_valid, overrun}, 32'd0);
        for (int c = 0; c < FILL; c++) begin
            applyStimulus(1'b1, 1'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] w, input logic rd);
        for (int k = 0; k < WIDTH; k++) begin
            applyStimulus(1'b1, w[k], 1'b1, rd);
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] enmask;
        int bit_no;
        rst_n = 1'b0; in = 1'b0; en = 1'b0; out_ready = 1'b0;
        rst_n_b = 1'b0; in_b = 1'b0; en_b = 1'b0; ready_b = 1'b0;
        @(negedge clk);

        // Basic capture: ignored fill bits, then 1,0,1,1,0,0,1,0 on cycles 4..11.
        resetAndFill();
        sendWord(8'h4D, 1'b0);
        checkOutput("basic_data", 32'(out_data), 32'h4D);
        checkOutput("basic_ones", 32'(ones_cnt), 32'd4);
        checkOutput("basic_valid", 32'(out_valid), 32'd1);

        // Enable gaps on cycles 6, 7 and 10; word visible in cycle 15.
        resetAndFill();
        pat = 8'h4D;
        enmask = 8'b1011_0011;
        bit_no = 0;
        for (int c = 4; c <= 14; c++) begin
            if (c == 6 || c == 7 || c == 10) begin
                applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0);
            end else begin
                applyStimulus(1'b1, pat[bit_no], 1'b1, 1'b0);
                bit_no++;
            end
            if (c == 13) checkOutput("gap_not_yet", 32'(out_valid), 32'd0);
        end
        checkOutput("gap_valid", 32'(out_valid), 32'd1);
        checkOutput("gap_data", 32'(out_data), 32'h4D);
        if (enmask == 8'hFF) $display("[TB] unreachable");

        // Backpressure: FF then 00 with out_ready low, then one accept pulse.
        resetAndFill();
        sendWord(8'hFF, 1'b0);
        checkOutput("bp_ovr_early", 32'(overrun), 32'd0);
        sendWord(8'h00, 1'b0);
        checkOutput("bp_data", 32'(out_data), 32'hFF);
        checkOutput("bp_ones", 32'(ones_cnt), 32'd8);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_overrun", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_accept_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_sticky", 32'(overrun), 32'd1);

        // Accept coincides with completion of the next word.
        resetAndFill();
        sendWord(8'hF0, 1'b0);
        pat = 8'h0F;
        for (int k = 0; k < WIDTH; k++) begin
            applyStimulus(1'b1, pat[k], 1'b1, (k == WIDTH-1));
        end
        checkOutput("sim_data", 32'(out_data), 32'h0F);
        checkOutput("sim_ones", 32'(ones_cnt), 32'd4);
        checkOutput("sim_valid", 32'(out_valid), 32'd1);
        checkOutput("sim_overrun", 32'(overrun), 32'd0);

        // Reset mid-word with a word pending, then a fresh word after refill.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        resetAndFill();
        sendWord(8'hA5, 1'b0);
        checkOutput("post_reset_data", 32'(out_data), 32'hA5);
        checkOutput("post_reset_ovr", 32'(overrun), 32'd0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom_range(0, 299) != 0), 1'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        // Second instance: WIDTH=4, no fill; 1,1,1,0 from cycle 0.
        @(posedge clk);
        @(negedge clk);
        checkOutput("b_reset", {data_b, ones_b, valid_b, overrun_b}, 32'd0);
        rst_n_b = 1'b1;
        en_b = 1'b1;
        pat = 8'h07;
        for (int k = 0; k < 4; k++) begin
            in_b = pat[k];
            @(posedge clk);
            @(negedge clk);
            if (k == 2) checkOutput("b_not_yet", 32'(valid_b), 32'd0);
        end
        checkOutput("b_data", 32'(data_b), 32'h7);
        checkOutput("b_ones", 32'(ones_b), 32'd3);
        checkOutput("b_valid", 32'(valid_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
